// File: rtl/nn_pkg.sv
// Shared definitions for the neural-network datapath: Q8.8 word format and
// the state type of the output deserializer.
package nn_pkg;

    localparam int DATA_WIDTH      = 16;
    localparam int DATA_INT_WIDTH  = 8;
    localparam int DATA_FRAC_WIDTH = 8;

    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } deser_state_t;

endpackage

// File: rtl/output_deserializer.sv
// Packs a serial stream of Q8.8 neuron outputs into one wide frame and holds
// it until the consumer acknowledges it with outReady.
module output_deserializer
    import nn_pkg::*;
#(
    parameter int numOutputs   = 10,
    parameter int dataWidth    = DATA_WIDTH,
    parameter int counterWidth = $clog2(numOutputs)
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             inValid,
    input  logic [dataWidth-1:0]             deserializerIn,
    input  logic                             outReady,
    output logic [numOutputs*dataWidth-1:0]  deserializerOut,
    output logic                             outValid,
    output logic [counterWidth-1:0]          count,
    output logic                             overflow
);

    localparam logic [counterWidth-1:0] LAST_SLOT = counterWidth'(numOutputs - 1);

    deser_state_t                state;
    deser_state_t                stateNext;
    logic [counterWidth-1:0]     countNext;
    logic                        outValidNext;
    logic                        overflowNext;
    logic                        acceptWord;
    logic [counterWidth-1:0]     writeSlot;
    logic [numOutputs-1:0]       slotWrite;

    // Next-state and control decode. A release in HOLD may accept a word on
    // the same edge, which then becomes slot 0 of the following frame.
    always_comb begin
        stateNext    = state;
        countNext    = count;
        outValidNext = outValid;
        overflowNext = overflow;
        acceptWord   = 1'b0;
        writeSlot    = count;
        case (state)
            COLLECT: begin
                if (inValid) begin
                    acceptWord = 1'b1;
                    if (count == LAST_SLOT) begin
                        countNext    = '0;
                        outValidNext = 1'b1;
                        stateNext    = HOLD;
                    end else begin
                        countNext = count + counterWidth'(1);
                    end
                end
            end
            HOLD: begin
                if (outReady) begin
                    outValidNext = 1'b0;
                    stateNext    = COLLECT;
                    writeSlot    = '0;
                    if (inValid) begin
                        acceptWord = 1'b1;
                        countNext  = counterWidth'(1);
                    end else begin
                        countNext = '0;
                    end
                end else if (inValid) begin
                    overflowNext = 1'b1;
                end
            end
            default: begin
                stateNext = COLLECT;
            end
        endcase
    end

    always_comb begin
        slotWrite = '0;
        for (int i = 0; i < numOutputs; i++) begin
            slotWrite[i] = acceptWord && (writeSlot == counterWidth'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= COLLECT;
            count           <= '0;
            outValid        <= 1'b0;
            overflow        <= 1'b0;
            deserializerOut <= '0;
        end else begin
            state    <= stateNext;
            count    <= countNext;
            outValid <= outValidNext;
            overflow <= overflowNext;
            for (int i = 0; i < numOutputs; i++) begin
                if (slotWrite[i]) begin
                    deserializerOut[i*dataWidth +: dataWidth] <= deserializerIn;
                end
            end
        end
    end

endmodule

// File: doc/output_deserializer.md
# output_deserializer

Collects the serial stream of Q8.8 values a layer's neurons produce (one value per `inValid` strobe) and packs them into one wide vector. It is the receive-side counterpart of `inputSerializer`: the packed vector and its `outValid` flag feed the next layer's serializer directly. A hold-until-acknowledged handshake keeps the vector stable until the consumer takes it.

## Interface
- `numOutputs`, default 10: words per frame (neurons in the producing layer); must be ≥ 2.
- `dataWidth`, default 16: bits per word (Q8.8).
- `counterWidth`, default `$clog2(numOutputs)`: width of the slot counter.

Clock and reset are decided: one clock, `clk`; reset `reset`, synchronous, active-high.

- `clk`  in  1  sole clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `inValid`  in  1  `deserializerIn` holds a valid word this cycle.
- `deserializerIn`  in  dataWidth  incoming word.
- `outReady`  in  1  consumer takes the frame at this edge (meaningful only while `outValid`).
- `deserializerOut`  out  numOutputs*dataWidth  packed frame; slot i = bits [i*dataWidth +: dataWidth].
- `outValid`  out  1  frame complete and stable.
- `count`  out  counterWidth  slot the next accepted word will fill.
- `overflow`  out  1  sticky: a word arrived while a full frame was held.

## Operation
- Two states: COLLECT and HOLD. Reset places the block in COLLECT.
- **Reset values:** `deserializerOut` = 0, `outValid` = 0, `count` = 0, `overflow` = 0.
- **COLLECT, `inValid` = 1:**
  - Write `deserializerIn` into slot `count`.
  - If `count` = numOutputs-1: `count` wraps to 0, set `outValid`, go to HOLD.
  - Otherwise `count` increments.
- **COLLECT, `inValid` = 0:** no change. Gaps between words of any length are legal.
- **Packing order:** the first word received goes to slot 0 (LSBs). This matches the order in which `inputSerializer` emits.
- **HOLD:** `deserializerOut` and `outValid` stay frozen until `outReady` = 1.
- **HOLD, `outReady` = 1, `inValid` = 0:** clear `outValid`, go to COLLECT, `count` stays 0.
- **HOLD, `outReady` = 1, `inValid` = 1 (same edge):**
  - Release the frame and write the word into slot 0.
  - `count` becomes 1; state goes to COLLECT.
  - No word is lost.
- **HOLD, `outReady` = 0, `inValid` = 1:**
  - The word is dropped and `overflow` is set.
  - `overflow` clears only on reset.
- **`outReady` while in COLLECT:** ignored.
- **Slot contents:** unwritten slots of a new frame keep stale values from the previous frame until overwritten. Consumers rely only on the frame presented while `outValid` is high.
- **Reset mid-frame or mid-HOLD:** any partial or held frame is discarded and every output returns to its reset value on that edge.
- **Arithmetic:** no arithmetic is applied to data; words are stored bit-exact.
- **Counter compare:** the wrap compare uses `counterWidth` bits. `count` never exceeds numOutputs-1.

## Timing
- A word is written at the edge where `inValid` is high and is visible on `deserializerOut` the next cycle.
- **Fill latency:** `outValid` rises 1 cycle after the edge that accepts the last word.
  - With back-to-back input, that is numOutputs edges after the first accepted word.
- **Fastest turnaround:** `outValid` is high for a minimum of 1 cycle. If `outReady` is held high, the block returns to COLLECT on the edge after `outValid` rises.
- **Throughput:** sustained 1 word/cycle, with no bubble at frame boundaries as long as `outReady` is high on the first HOLD cycle.
- **Register timing:** all outputs are registered, with no combinational path from inputs to outputs.

## Structure
- **Shared package `nn_pkg`:**
  - Typedef `deser_state_t {COLLECT, HOLD}`.
  - Q8.8 constants `DATA_WIDTH = 16`, `DATA_INT_WIDTH = 8`, `DATA_FRAC_WIDTH = 8`, also used by neuron and `inputSerializer`.
- **No sub-module.** The slot counter and the per-slot write enables are simple enough to keep inline.

## Test plan
Bench: numOutputs = 4, dataWidth = 16.
1. Reset asserted for 1 cycle → all outputs read 0 on the next cycle. `outReady` pulsed in COLLECT → no change.
2. Back-to-back words 0x0100, 0x0280, 0xFF00, 0x0040, `outReady` = 0 → `outValid` rises 1 cycle after the 4th word; `deserializerOut` = 0x0040_FF00_0280_0100; `count` = 0.
3. Same words with 3-cycle gaps, then `outReady` held low 5 cycles, then pulsed → frame stays stable throughout HOLD; `outValid` falls on the edge after the `outReady` pulse.
4. In HOLD, `inValid` = 1 with 0x1234, `outReady` = 0 → word dropped, `overflow` = 1 and stays 1. Next, `outReady` = 1 together with `inValid` 0x5678 → 0x5678 lands in slot 0, `count` = 1.
5. Two consecutive frames with `outReady` tied high and continuous input → two `outValid` pulses, 4 cycles apart, each carrying the correct packed frame; `overflow` stays 0.
6. Reset asserted after 2 of 4 words → outputs return to 0. Then 4 fresh words → clean frame with no stale partial data.
